// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back queue in front of the register file's
// single write port. Two producers (ALU = A, load = B) push through
// valid/ready handshakes. The head entry drains combinationally onto
// o_wen/o_wreg/o_wdata.
// Optional feature macro: WBQ_BYPASS_EN builds the read-address forwarding
// comparators. When it is undefined, the forwarding outputs are tied to 0.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_a_valid,
  input  logic [AW-1:0]            i_a_reg,
  input  logic [DW-1:0]            i_a_data,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic [AW-1:0]            i_b_reg,
  input  logic [DW-1:0]            i_b_data,
  output logic                     o_b_ready,
  input  logic                     i_hold,
  output logic                     o_wen,
  output logic [AW-1:0]            o_wreg,
  output logic [DW-1:0]            o_wdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  input  logic [AW-1:0]            i_raddr1,
  input  logic [AW-1:0]            i_raddr2,
  output logic                     o_fwd_hit1,
  output logic [DW-1:0]            o_fwd_data1,
  output logic                     o_fwd_hit2,
  output logic [DW-1:0]            o_fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] ent_reg  [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          a_push, b_push, pop;
  logic [PW-1:0] b_slot;

  // Handshake, push/pop qualification and head drain
  always_comb begin
    free      = CW'(DEPTH) - count;
    o_a_ready = (free >= CW'(1));
    // A reserves a slot whenever it is valid, so B needs a second free slot
    o_b_ready = i_a_valid ? (free >= CW'(2)) : (free >= CW'(1));
    // Register 0 writes are acknowledged but never stored
    a_push    = i_a_valid && o_a_ready && (i_a_reg != '0) && !i_flush;
    b_push    = i_b_valid && o_b_ready && (i_b_reg != '0) && !i_flush;
    b_slot    = wr_ptr + PW'(a_push);
    o_empty   = (count == '0);
    o_full    = (count == CW'(DEPTH));
    o_count   = count;
    o_wen     = !o_empty && !i_hold;
    o_wreg    = ent_reg[rd_ptr];
    o_wdata   = ent_data[rd_ptr];
    pop       = o_wen;
  end

  // Pointer and occupancy update; reset takes precedence over flush
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(a_push) + PW'(b_push);
      count  <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
    end
  end

  // Entry storage; A lands first so B is the younger entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (a_push) begin
        ent_reg[wr_ptr]  <= i_a_reg;
        ent_data[wr_ptr] <= i_a_data;
      end
      if (b_push) begin
        ent_reg[b_slot]  <= i_b_reg;
        ent_data[b_slot] <= i_b_data;
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  // Walk oldest to youngest so that the last match (the youngest) wins
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (addr != '0 && i < 32'(count) && ent_reg[idx] == addr)
        res = {1'b1, ent_data[idx]};
    end
    return res;
  endfunction

  // Forwarding lookup over stored entries only
  always_comb begin
    {o_fwd_hit1, o_fwd_data1} = lookup(i_raddr1);
    {o_fwd_hit2, o_fwd_data2} = lookup(i_raddr2);
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{i_raddr1, i_raddr2};

  // Forwarding disabled: outputs held at zero
  always_comb begin
    o_fwd_hit1  = 1'b0;
    o_fwd_data1 = '0;
    o_fwd_hit2  = 1'b0;
    o_fwd_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a queue-based model checked on every negedge,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, i_flush, i_hold;
  logic        i_a_valid, i_b_valid;
  logic [4:0]  i_a_reg, i_b_reg, i_raddr1, i_raddr2;
  logic [31:0] i_a_data, i_b_data;
  logic        o_a_ready, o_b_ready, o_wen, o_empty, o_full;
  logic [4:0]  o_wreg;
  logic [31:0] o_wdata, o_fwd_data1, o_fwd_data2;
  logic [2:0]  o_count;
  logic        o_fwd_hit1, o_fwd_hit2;

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_a_valid(i_a_valid), .i_a_reg(i_a_reg), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_reg(i_b_reg), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .i_hold(i_hold), .o_wen(o_wen), .o_wreg(o_wreg), .o_wdata(o_wdata),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_fwd_hit1(o_fwd_hit1), .o_fwd_data1(o_fwd_data1),
    .o_fwd_hit2(o_fwd_hit2), .o_fwd_data2(o_fwd_data2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t q[$];

  function automatic void fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
`ifdef WBQ_BYPASS_EN
    if (a != 0)
      foreach (q[k]) if (q[k].r == a) begin h = 1'b1; d = q[k].d; end
`endif
  endfunction

  // Model: list of pending writes, updated with the spec's per-cycle rules
  always @(posedge clk) begin
    int f;
    bit ar, br;
    if (rst || i_flush) q.delete();
    else begin
      f  = DEPTH - q.size();
      ar = (f >= 1);
      br = i_a_valid ? (f >= 2) : (f >= 1);
      if (q.size() > 0 && !i_hold) void'(q.pop_front());
      if (i_a_valid && ar && i_a_reg != 0) q.push_back('{i_a_reg, i_a_data});
      if (i_b_valid && br && i_b_reg != 0) q.push_back('{i_b_reg, i_b_data});
    end
  end

  // Compare every cycle at the negedge against the model
  always @(negedge clk) begin
    int n, f;
    logic h;
    logic [31:0] d;
    if (chk_en) begin
      n = q.size();
      f = DEPTH - n;
      chk("count", 32'(o_count), 32'(n));
      chk("empty", 32'(o_empty), 32'(n == 0));
      chk("full", 32'(o_full), 32'(n == DEPTH));
      chk("a_ready", 32'(o_a_ready), 32'(f >= 1));
      chk("b_ready", 32'(o_b_ready), 32'(i_a_valid ? (f >= 2) : (f >= 1)));
      chk("wen", 32'(o_wen), 32'(n > 0 && !i_hold));
      if (n > 0) begin
        chk("wreg", 32'(o_wreg), 32'(q[0].r));
        chk("wdata", o_wdata, q[0].d);
      end
      fwd(i_raddr1, h, d);
      chk("fwd_hit1", 32'(o_fwd_hit1), 32'(h));
      chk("fwd_data1", o_fwd_data1, d);
      fwd(i_raddr2, h, d);
      chk("fwd_hit2", 32'(o_fwd_hit2), 32'(h));
      chk("fwd_data2", o_fwd_data2, d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_a_valid = 0; i_b_valid = 0; i_flush = 0;
    i_a_reg = 0; i_a_data = 0; i_b_reg = 0; i_b_data = 0;
  endtask

  task automatic pa(input logic [4:0] r, input logic [31:0] d);
    i_a_valid = 1; i_a_reg = r; i_a_data = d;
  endtask

  task automatic pb(input logic [4:0] r, input logic [31:0] d);
    i_b_valid = 1; i_b_reg = r; i_b_data = d;
  endtask

  initial begin
    rst = 1; i_hold = 0; i_raddr1 = 0; i_raddr2 = 0;
    idle();
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // 1: reset mid-traffic
    i_hold = 1; i_raddr1 = 1; i_raddr2 = 2;
    pa(1, 32'h5); pb(2, 32'h6);
    tick();
    rst = 1;
    tick(); tick();
    rst = 0; idle();
    #1;
    chk("t1_empty", 32'(o_empty), 1);
    chk("t1_count", 32'(o_count), 0);
    chk("t1_wen", 32'(o_wen), 0);
    chk("t1_hit1", 32'(o_fwd_hit1), 0);
    chk("t1_hit2", 32'(o_fwd_hit2), 0);

    // 2: A only, back-to-back drain
    i_hold = 0; i_raddr1 = 0; i_raddr2 = 0;
    pa(3, 32'h11); tick();
    pa(4, 32'h22); #1;
    chk("t2_wen0", 32'(o_wen), 1);
    chk("t2_wreg0", 32'(o_wreg), 3);
    chk("t2_wdata0", o_wdata, 32'h11);
    tick(); idle(); #1;
    chk("t2_wen1", 32'(o_wen), 1);
    chk("t2_wreg1", 32'(o_wreg), 4);
    chk("t2_wdata1", o_wdata, 32'h22);
    tick(); #1;
    chk("t2_empty", 32'(o_empty), 1);

    // 3: dual push with a single free slot
    i_hold = 1;
    for (int i = 1; i <= 3; i++) begin pa(5'(i), 32'(i)); tick(); end
    pa(5, 32'hA); pb(6, 32'hB); #1;
    chk("t3_count", 32'(o_count), 3);
    chk("t3_a_ready", 32'(o_a_ready), 1);
    chk("t3_b_ready", 32'(o_b_ready), 0);
    tick();
    i_a_valid = 0; i_hold = 0; #1;
    chk("t3_full_b_ready", 32'(o_b_ready), 0);
    chk("t3_pop_wreg", 32'(o_wreg), 1);
    tick(); #1;
    chk("t3_after_pop_b_ready", 32'(o_b_ready), 1);
    tick(); idle();
    for (int i = 0; i < 4; i++) tick();
    chk("t3_drained", 32'(o_empty), 1);

    // 4: fill under hold, full with pop, drain, then wrap
    i_hold = 1;
    for (int i = 0; i < 4; i++) begin pa(5'(8 + i), 32'h100 + 32'(i)); tick(); end
    pa(12, 32'h1FF); #1;
    chk("t4_full", 32'(o_full), 1);
    chk("t4_a_ready", 32'(o_a_ready), 0);
    i_hold = 0; #1;
    chk("t4_head", 32'(o_wreg), 8);
    tick(); idle();
    for (int i = 0; i < 3; i++) tick();
    chk("t4_drained", 32'(o_empty), 1);
    i_hold = 1;
    for (int i = 0; i < 4; i++) begin pa(5'(20 + i), 32'h200 + 32'(i)); tick(); end
    idle(); i_hold = 0; #1;
    chk("t4_wrap_head", 32'(o_wreg), 20);
    for (int i = 0; i < 4; i++) tick();

    // 5: r0 drop, then flush with a concurrent push
    pa(0, 32'hFF); #1;
    chk("t5_r0_ready", 32'(o_a_ready), 1);
    tick(); idle(); #1;
    chk("t5_r0_count", 32'(o_count), 0);
    chk("t5_r0_wen", 32'(o_wen), 0);
    i_hold = 1;
    for (int i = 1; i <= 3; i++) begin pa(5'(i), 32'h30 + 32'(i)); tick(); end
    pa(4, 32'h34); i_flush = 1;
    tick(); idle(); #1;
    chk("t5_flush_count", 32'(o_count), 0);
    chk("t5_flush_empty", 32'(o_empty), 1);

    // 6: forwarding, younger B entry wins
    pa(7, 32'h1); pb(7, 32'h2);
    tick(); idle();
    i_raddr1 = 7; i_raddr2 = 0; #1;
`ifdef WBQ_BYPASS_EN
    chk("t6_hit1", 32'(o_fwd_hit1), 1);
    chk("t6_data1", o_fwd_data1, 32'h2);
`else
    chk("t6_hit1", 32'(o_fwd_hit1), 0);
    chk("t6_data1", o_fwd_data1, 0);
`endif
    chk("t6_hit2", 32'(o_fwd_hit2), 0);
    i_hold = 0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
